// File: rtl/pulse_meter.sv
// pulse_meter: measures a pulse against a trigger rising edge.
//   delay_out = cycles from the accepted trigger edge to the pulse rise, minus 1
//   width_out = cycles the pulse was sampled high
// Each result is held with valid until ack_in. A non-zero timeout aborts a
// stuck measurement and flags it with timed_out.
//
// Optional feature: define PULSE_METER_SYNC_EN to put two-flop synchronisers
// on trigger_in and pulse_in. This shifts busy/valid two cycles later and
// leaves the measured values unchanged.
//
// Ports:
//   clk        clock, all logic on posedge
//   reset_n    synchronous active-low reset
//   trigger_in measurement start (rising edge)
//   pulse_in   pulse under measurement (level)
//   timeout    abort limit in cycles, 0 = disabled
//   ack_in     consumer acknowledge of the held result
//   busy       measurement in progress
//   valid      result held, awaiting ack_in
//   delay_out  measured delay
//   width_out  measured width
//   timed_out  held result was aborted by timeout
//   overrun    sticky: trigger edge seen while not idle
module pulse_meter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        trigger_in,
    input  logic        pulse_in,
    input  logic [31:0] timeout,
    input  logic        ack_in,
    output logic        busy,
    output logic        valid,
    output logic [31:0] delay_out,
    output logic [31:0] width_out,
    output logic        timed_out,
    output logic        overrun
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_MEAS = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state;
    logic [31:0] count;
    logic [31:0] count_inc;
    logic        trig_s;
    logic        pulse_s;
    logic        trig_prev;
    logic        trig_edge;
    logic        to_hit;

`ifdef PULSE_METER_SYNC_EN
    logic [1:0] trig_sync;
    logic [1:0] pulse_sync;

    // Trigger path resets high so a trigger held through reset is not seen
    // as a fresh edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            trig_sync  <= 2'b11;
            pulse_sync <= 2'b00;
        end else begin
            trig_sync  <= {trig_sync[0], trigger_in};
            pulse_sync <= {pulse_sync[0], pulse_in};
        end
    end

    assign trig_s  = trig_sync[1];
    assign pulse_s = pulse_sync[1];
`else
    assign trig_s  = trigger_in;
    assign pulse_s = pulse_in;
`endif

    assign trig_edge = trig_s && !trig_prev;
    assign to_hit    = (timeout != 32'd0) && (count == timeout);
    // Counter saturates instead of wrapping (only reachable with timeout 0).
    assign count_inc = (count == 32'hFFFF_FFFF) ? count : count + 32'd1;

    assign busy  = (state == S_WAIT) || (state == S_MEAS);
    assign valid = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            count     <= 32'd0;
            delay_out <= 32'd0;
            width_out <= 32'd0;
            timed_out <= 1'b0;
            overrun   <= 1'b0;
            trig_prev <= 1'b1;
        end else begin
            trig_prev <= trig_s;
            if (trig_edge && state != S_IDLE)
                overrun <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (trig_edge) begin
                        count <= 32'd0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (pulse_s) begin
                        delay_out <= count;
                        count     <= 32'd1;
                        state     <= S_MEAS;
                    end else if (to_hit) begin
                        delay_out <= count;
                        width_out <= 32'd0;
                        timed_out <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        count <= count_inc;
                    end
                end
                S_MEAS: begin
                    if (!pulse_s) begin
                        width_out <= count;
                        state     <= S_DONE;
                    end else if (to_hit) begin
                        width_out <= count;
                        timed_out <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        count <= count_inc;
                    end
                end
                default: begin
                    // A trigger edge coinciding with the ack is dropped but
                    // still reported: overrun survives the clear.
                    if (ack_in) begin
                        timed_out <= 1'b0;
                        overrun   <= trig_edge;
                        state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_meter.sv
module tb_pulse_meter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        trigger_in = 1'b0;
    logic        pulse_in = 1'b0;
    logic [31:0] timeout = 32'd0;
    logic        ack_in = 1'b0;
    logic        busy, valid, timed_out, overrun;
    logic [31:0] delay_out, width_out;

`ifdef PULSE_METER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    pulse_meter dut (
        .clk(clk), .reset_n(reset_n), .trigger_in(trigger_in),
        .pulse_in(pulse_in), .timeout(timeout), .ack_in(ack_in),
        .busy(busy), .valid(valid), .delay_out(delay_out),
        .width_out(width_out), .timed_out(timed_out), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Edge index: after posedge n settles, cyc == n.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int dly;
        int wid;
        bit to;
        bit ov;
        int vcyc;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    logic vprev = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_delay"}, delay_out, 0);
        chk({tag, "_width"}, width_out, 0);
        chk({tag, "_timed_out"}, timed_out, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    // One measurement: pulse rises d cycles after the edge following the
    // trigger edge and stays high w samples. pre holds the pulse high from
    // before the trigger (requires d=0). ov injects a second trigger edge
    // two cycles after the first, always while measuring.
    task automatic run_txn(input int d, input int w, input int t, input bit pre, input bit ov);
        exp_t e;
        int   etrig;
        bit   got;
        timeout    = t;
        pulse_in   = pre;
        trigger_in = 1'b0;
        step();
        etrig = cyc + 1;

        // Reference: the pulse rise wins a tie with the timeout, as does
        // the fall; otherwise the earlier event decides the outcome.
        e.ov = ov;
        if (t != 0 && t < d) begin
            e.dly = t; e.wid = 0; e.to = 1; e.vcyc = etrig + 1 + t;
        end else if (t != 0 && t < w) begin
            e.dly = d; e.wid = t; e.to = 1; e.vcyc = etrig + 1 + d + t;
        end else begin
            e.dly = d; e.wid = w; e.to = 0; e.vcyc = etrig + 1 + d + w;
        end
        e.vcyc += LAT;
        q.push_back(e);

        got = 1'b0;
        for (int j = 0; j < 300 && !got; j++) begin
            trigger_in = (j == 0) || (ov && j == 2);
            pulse_in   = (pre && j == 0) || (j >= 1 + d && j < 1 + d + w);
            step();
            got = valid;
        end
        chk("valid_within_budget", got, 1);
        if (!got) q.delete();

        pulse_in   = 1'b0;
        trigger_in = 1'b0;
        repeat ($urandom_range(0, 3)) step();
        ack_in = 1'b1;
        step();
        ack_in = 1'b0;
        chk("post_ack_valid", valid, 0);
        chk("post_ack_timed_out", timed_out, 0);
        chk("post_ack_overrun", overrun, 0);
        step();
    endtask

    // Monitor: every valid rise is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid && !vprev) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("delay_out", delay_out, e.dly);
                    chk("width_out", width_out, e.wid);
                    chk("timed_out", timed_out, e.to);
                    chk("overrun", overrun, e.ov);
                    chk("valid_cycle", cyc, e.vcyc);
                    chk("busy_at_valid", busy, 0);
                end
            end
            vprev = valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, w, t;
        bit pre, ov;

        repeat (3) step();
        chk_zero("reset");
        reset_n = 1'b1;
        step();

        run_txn(4, 3, 0, 1'b0, 1'b0);   // basic: delay 4, width 3
        run_txn(8, 3, 0, 1'b0, 1'b0);   // loopback-style: delay 8, width 3
        run_txn(50, 1, 10, 1'b0, 1'b0); // no pulse in time: delay 10, width 0
        run_txn(0, 20, 6, 1'b1, 1'b0);  // already high: delay 0, width 6, timed out
        run_txn(2, 5, 0, 1'b0, 1'b1);   // second trigger while measuring
        run_txn(5, 5, 5, 1'b0, 1'b0);   // both ties go to the pulse

        // Reset in WAIT_RISE with the trigger held high.
        timeout    = 32'd0;
        trigger_in = 1'b0;
        step();
        trigger_in = 1'b1;
        repeat (2 + LAT) step();
        chk("busy_before_reset", busy, 1);
        reset_n = 1'b0;
        step();
        chk_zero("mid_reset");
        reset_n = 1'b1;
        repeat (4) begin
            step();
            chk("held_trigger_ignored", busy, 0);
        end
        trigger_in = 1'b0;
        step();

        for (int i = 0; i < 30; i++) begin
            d   = $urandom_range(0, 12);
            w   = $urandom_range(1, 12);
            t   = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 15);
            pre = (d == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            ov  = 1'($urandom_range(0, 1));
            run_txn(d, w, t, pre, ov);
        end

        repeat (5) step();
        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
